mem_main_banked: RTL and testbench
==================================

// Module: mem_main_banked
// PURPOSE
//  Shared main memory for NUM_RT ray-tracer cores plus one read-only memory-controller (MC) port.
//  Storage is split into NUM_BANK word-interleaved single-port banks; each bank has its own round-robin
//  arbiter, so requests to different banks complete in the same cycle.
//  Sits between the RT cores / MC and on-chip storage; successor of the single-array main memory.
// PARAMETERS
//  NUM_RT      4     number of RT requester ports
//  DATA_W      128   word width (bits)
//  ADDR_W      32    word address width
//  NUM_BANK    4     bank count, power of 2, >=2
//  BANK_DEPTH  1024  words per bank, power of 2
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  we_RT        in   [NUM_RT]        write request per RT port
//  re_RT        in   [NUM_RT]        read request per RT port
//  addr_RT      in   ADDR_W x NUM_RT word address per RT port
//  data_RT_in   in   DATA_W x NUM_RT write data per RT port
//  re_MC        in   1               MC read request
//  addr_MC      in   ADDR_W          MC word address
//  rdy_RT       out  [NUM_RT]        1-cycle completion pulse per RT port
//  data_RT_out  out  DATA_W x NUM_RT read data per RT port
//  rdy_MC       out  1               1-cycle MC completion pulse
//  data_MC_out  out  DATA_W          MC read data
// BEHAVIOUR
//  - Address map: bank = addr[log2(NUM_BANK)-1:0]; row = next log2(BANK_DEPTH) bits; upper bits ignored (alias).
//  - Request: port i requests when (we|re) is high and its rdy is low this cycle. Requests are masked in the
//    cycle rdy is high. Max rate per port: one access per 2 cycles.
//  - we and re both high: treated as a write; data_RT_out unchanged.
//  - Requester holds addr/data/we/re stable until rdy; it changes or drops them at the edge ending the rdy cycle.
//  - Arbitration (per bank, cycle N): the candidate order is RT0..RT(NUM_RT-1), then MC at index NUM_RT.
//    - Pointer ptr[b] resets to 0.
//    - Grant goes to the first requester at or after ptr[b], with wrap.
//    - On a grant, ptr[b] <= (granted+1) mod (NUM_RT+1). ptr[b] is unchanged when there is no grant.
//  - Granted access uses the bank RAM in cycle N: a write commits at the N edge; a read is captured at the N edge.
//  - Cycle N+1: rdy pulses high for exactly 1 cycle. For a read, data_*_out is valid and holds until the next read completes.
//  - Losers keep requesting; they are never dropped. Starvation bound: NUM_RT cycles of waiting with all ports hammering one bank.
//  - Same-cycle write and read to the same address: only one is granted, so ordering is fixed by grant order.
//    A read granted after the write sees the new data.
//  - Latency with no contention: request cycle N -> rdy cycle N+1.
//  - Reset values: rdy_RT=0, rdy_MC=0, data_RT_out=0, data_MC_out=0, ptr=0. RAM contents are not reset (undefined).
//  - Reset asserted mid-access: in-flight grants are dropped, no rdy is issued, and a write whose edge has not occurred is lost.
//  - Outputs are registered; there is no combinational path from inputs to rdy or data.
// CONFIGURATION
//  MEM_MC_PRIORITY_EN defined:
//    - MC is removed from the rotation and wins its bank whenever it requests.
//    - RT arbiters rotate over NUM_RT only: ptr <= (granted+1) mod NUM_RT, and ptr is unchanged on an MC grant.
//  MEM_MC_PRIORITY_EN undefined: MC participates in round-robin as index NUM_RT (default).
// TESTING
//  1. Uncontended write then read:
//     - RT0 we addr=0x5, data=0xA5A5..; 2 cycles later re addr=0x5.
//     - Expect rdy_RT[0] one cycle after each request and data_RT_out[0]=0xA5A5.. on the read rdy.
//  2. Parallel banks: RT0..RT3 read addrs 0,1,2,3 in the same cycle -> all four rdy_RT high in the same next cycle.
//  3. Full conflict: RT0..RT3 and MC read addr 0x4 (bank 0) continuously.
//     - Default: grant order 0,1,2,3,MC,0..., one per cycle. MC is served within 5 cycles.
//     - With MEM_MC_PRIORITY_EN: MC is served first.
//  4. we+re both high from RT2 addr=0x9 data=0x77 -> write performed, data_RT_out[2] unchanged, later read of 0x9 returns 0x77.
//  5. Aliasing: write addr=BANK_DEPTH*NUM_BANK+3, then read addr=3 -> same data returned.
//  6. Reset mid-op: assert rst_n=0 in the grant cycle of an RT1 read -> no rdy_RT[1]; all outputs 0 while in reset; ptr=0 after.

Source files
------------

// File: rtl/mem_main_banked.sv
// Banked shared main memory: NUM_RT ray-tracer ports plus one read-only MC port.
// Word-interleaved single-port banks, each with its own round-robin arbiter.
// Optional feature macro: MEM_MC_PRIORITY_EN (MC wins its bank whenever it requests).
module mem_main_banked #(
   parameter int unsigned NUM_RT     = 4,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned NUM_BANK   = 4,
   parameter int unsigned BANK_DEPTH = 1024
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_RT-1:0]              we_RT,
   input  logic [NUM_RT-1:0]              re_RT,
   input  logic [NUM_RT-1:0][ADDR_W-1:0]  addr_RT,
   input  logic [NUM_RT-1:0][DATA_W-1:0]  data_RT_in,
   input  logic                           re_MC,
   input  logic [ADDR_W-1:0]              addr_MC,
   output logic [NUM_RT-1:0]              rdy_RT,
   output logic [NUM_RT-1:0][DATA_W-1:0]  data_RT_out,
   output logic                           rdy_MC,
   output logic [DATA_W-1:0]              data_MC_out
);

   localparam int unsigned NUM_C  = NUM_RT + 1;
   localparam int unsigned MC_IDX = NUM_RT;
   localparam int unsigned PTR_W  = $clog2(NUM_C);
   localparam int unsigned BANK_W = $clog2(NUM_BANK);
   localparam int unsigned ROW_W  = $clog2(BANK_DEPTH);
`ifdef MEM_MC_PRIORITY_EN
   localparam int unsigned RR_N   = NUM_RT;
`else
   localparam int unsigned RR_N   = NUM_C;
`endif

   logic [NUM_RT-1:0]              req_rt;
   logic                           req_mc;
   logic [BANK_W-1:0]              bank_rt [NUM_RT];
   logic [ROW_W-1:0]               row_rt  [NUM_RT];
   logic [BANK_W-1:0]              bank_mc;
   logic [ROW_W-1:0]               row_mc;
   logic [NUM_C-1:0]               cand    [NUM_BANK];
   logic [NUM_BANK-1:0]            found;
   logic [PTR_W-1:0]               win     [NUM_BANK];
   logic [PTR_W-1:0]               ptr     [NUM_BANK];
   logic [PTR_W-1:0]               ptr_nxt [NUM_BANK];
   logic [PTR_W-1:0]               idx;
   logic [ROW_W-1:0]               row_sel [NUM_BANK];
   logic [NUM_BANK-1:0]            wr_en;
   logic [DATA_W-1:0]              wdata   [NUM_BANK];
   logic [DATA_W-1:0]              rdata   [NUM_BANK];
   logic [NUM_RT-1:0]              gnt_rt;
   logic                           gnt_mc;
   logic [DATA_W-1:0]              mem     [NUM_BANK][BANK_DEPTH];
   logic                           unused_addr_hi;

   // Upper address bits alias onto the same words and are deliberately ignored.
   assign unused_addr_hi = ^{addr_RT, addr_MC};

   // A port may not re-request in the cycle its completion pulse is high.
   assign req_rt = (we_RT | re_RT) & ~rdy_RT;
   assign req_mc = re_MC & ~rdy_MC;

   // Address split: low bits select the bank, next bits select the row.
   always_comb begin
      for (int i = 0; i < int'(NUM_RT); i++) begin
         bank_rt[i] = addr_RT[i][BANK_W-1:0];
         row_rt[i]  = addr_RT[i][BANK_W +: ROW_W];
      end
      bank_mc = addr_MC[BANK_W-1:0];
      row_mc  = addr_MC[BANK_W +: ROW_W];
   end

   // Per-bank arbitration and bank-port mux for the winning requester.
   always_comb begin
      idx = '0;
      for (int b = 0; b < int'(NUM_BANK); b++) begin
         cand[b]    = '0;
         found[b]   = 1'b0;
         win[b]     = '0;
         ptr_nxt[b] = ptr[b];
         row_sel[b] = '0;
         wr_en[b]   = 1'b0;
         wdata[b]   = '0;
         for (int i = 0; i < int'(NUM_RT); i++)
            cand[b][i] = req_rt[i] && (bank_rt[i] == BANK_W'(b));
         cand[b][MC_IDX] = req_mc && (bank_mc == BANK_W'(b));
`ifdef MEM_MC_PRIORITY_EN
         if (cand[b][MC_IDX]) begin
            found[b] = 1'b1;
            win[b]   = PTR_W'(MC_IDX);
         end
`endif
         for (int k = 0; k < int'(RR_N); k++) begin
            idx = PTR_W'((int'(ptr[b]) + k) % int'(RR_N));
            if (!found[b] && cand[b][idx]) begin
               found[b]   = 1'b1;
               win[b]     = idx;
               ptr_nxt[b] = PTR_W'((int'(ptr[b]) + k + 1) % int'(RR_N));
            end
         end
         if (found[b]) begin
            if (win[b] == PTR_W'(MC_IDX)) begin
               row_sel[b] = row_mc;
            end else begin
               for (int i = 0; i < int'(NUM_RT); i++) begin
                  if (win[b] == PTR_W'(i)) begin
                     row_sel[b] = row_rt[i];
                     wr_en[b]   = we_RT[i];
                     wdata[b]   = data_RT_in[i];
                  end
               end
            end
         end
      end
   end

   // Each port maps to exactly one bank, so its grant comes from that bank's arbiter.
   always_comb begin
      for (int i = 0; i < int'(NUM_RT); i++)
         gnt_rt[i] = found[bank_rt[i]] && (win[bank_rt[i]] == PTR_W'(i));
      gnt_mc = found[bank_mc] && (win[bank_mc] == PTR_W'(MC_IDX));
   end

   // Asynchronous read of each bank at the granted row.
   always_comb begin
      for (int b = 0; b < int'(NUM_BANK); b++)
         rdata[b] = mem[b][row_sel[b]];
   end

   // Bank RAM writes; an edge seen while reset is asserted commits nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n) begin
         for (int b = 0; b < int'(NUM_BANK); b++)
            if (wr_en[b]) mem[b][row_sel[b]] <= wdata[b];
      end
   end

   // Arbiter pointers, completion pulses and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < int'(NUM_BANK); b++) ptr[b] <= '0;
         rdy_RT      <= '0;
         data_RT_out <= '0;
         rdy_MC      <= 1'b0;
         data_MC_out <= '0;
      end else begin
         for (int b = 0; b < int'(NUM_BANK); b++) ptr[b] <= ptr_nxt[b];
         for (int i = 0; i < int'(NUM_RT); i++) begin
            rdy_RT[i] <= gnt_rt[i];
            if (gnt_rt[i] && !we_RT[i]) data_RT_out[i] <= rdata[bank_rt[i]];
         end
         rdy_MC <= gnt_mc;
         if (gnt_mc) data_MC_out <= rdata[bank_mc];
      end
   end

endmodule

// File: tb/tb_mem_main_banked.sv
// Self-checking bench for mem_main_banked: directed scenarios plus randomized
// traffic compared against a transaction-level memory/arbitration model.
module tb_mem_main_banked;

   localparam int NUM_RT     = 4;
   localparam int DATA_W     = 128;
   localparam int ADDR_W     = 32;
   localparam int NUM_BANK   = 4;
   localparam int BANK_DEPTH = 1024;
   localparam int NUM_C      = NUM_RT + 1;
   localparam int SPAN       = NUM_BANK * BANK_DEPTH;

   logic                          clk;
   logic                          rst_n;
   logic [NUM_RT-1:0]             we_RT, re_RT;
   logic [NUM_RT-1:0][ADDR_W-1:0] addr_RT;
   logic [NUM_RT-1:0][DATA_W-1:0] data_RT_in;
   logic                          re_MC;
   logic [ADDR_W-1:0]             addr_MC;
   logic [NUM_RT-1:0]             rdy_RT;
   logic [NUM_RT-1:0][DATA_W-1:0] data_RT_out;
   logic                          rdy_MC;
   logic [DATA_W-1:0]             data_MC_out;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_out [NUM_RT];
   logic [DATA_W-1:0] c4_data;

   // Reference model state for randomized traffic.
   logic              act [NUM_C];
   logic              wop [NUM_C];
   logic              rop [NUM_C];
   logic [31:0]       ta  [NUM_C];
   logic [DATA_W-1:0] td  [NUM_C];
   logic              cur_rdy [NUM_C];
   logic              nxt_rdy [NUM_C];
   logic              req [NUM_C];
   logic [DATA_W-1:0] ed  [NUM_C];
   logic              ck  [NUM_C];
   int                mptr [NUM_BANK];
   logic [DATA_W-1:0] mdl [int];

   mem_main_banked #(
      .NUM_RT(NUM_RT), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .NUM_BANK(NUM_BANK), .BANK_DEPTH(BANK_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .we_RT(we_RT), .re_RT(re_RT), .addr_RT(addr_RT), .data_RT_in(data_RT_in),
      .re_MC(re_MC), .addr_MC(addr_MC),
      .rdy_RT(rdy_RT), .data_RT_out(data_RT_out),
      .rdy_MC(rdy_MC), .data_MC_out(data_MC_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_inputs();
      we_RT = '0; re_RT = '0; addr_RT = '0; data_RT_in = '0;
      re_MC = 1'b0; addr_MC = '0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rdy_RT !== '0) begin errors++; $display("FAIL reset_rdy_rt got %b exp 0", rdy_RT); end
      checks++; if (rdy_MC !== 1'b0) begin errors++; $display("FAIL reset_rdy_mc got %b exp 0", rdy_MC); end
      checks++; if (data_RT_out !== '0) begin errors++; $display("FAIL reset_data_rt got %h exp 0", data_RT_out); end
      checks++; if (data_MC_out !== '0) begin errors++; $display("FAIL reset_data_mc got %h exp 0", data_MC_out); end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NUM_RT; i++) exp_out[i] = '0;
   endtask

   task automatic test_uncontended();
      we_RT[0] = 1'b1; addr_RT[0] = 32'h5; data_RT_in[0] = {4{32'hA5A5A5A5}};
      step();
      checks++; if (rdy_RT !== 4'b0001) begin errors++; $display("FAIL unc_wr_rdy got %b exp 0001", rdy_RT); end
      we_RT[0] = 1'b0;
      @(negedge clk);
      checks++; if (rdy_RT !== 4'b0000) begin errors++; $display("FAIL unc_rdy_pulse got %b exp 0000", rdy_RT); end
      re_RT[0] = 1'b1;
      step();
      checks++; if (rdy_RT !== 4'b0001) begin errors++; $display("FAIL unc_rd_rdy got %b exp 0001", rdy_RT); end
      checks++; if (data_RT_out[0] !== {4{32'hA5A5A5A5}}) begin
         errors++; $display("FAIL unc_rd_data got %h exp %h", data_RT_out[0], {4{32'hA5A5A5A5}}); end
      exp_out[0] = {4{32'hA5A5A5A5}};
      re_RT[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_parallel();
      for (int i = 0; i < NUM_RT; i++) begin
         we_RT[i] = 1'b1; addr_RT[i] = ADDR_W'(i); data_RT_in[i] = {4{32'h1000_0000 + 32'(i)}};
      end
      step();
      checks++; if (rdy_RT !== 4'b1111) begin errors++; $display("FAIL par_wr_rdy got %b exp 1111", rdy_RT); end
      we_RT = '0;
      @(negedge clk);
      re_RT = '1;
      step();
      checks++; if (rdy_RT !== 4'b1111) begin errors++; $display("FAIL par_rd_rdy got %b exp 1111", rdy_RT); end
      for (int i = 0; i < NUM_RT; i++) begin
         exp_out[i] = {4{32'h1000_0000 + 32'(i)}};
         checks++; if (data_RT_out[i] !== exp_out[i]) begin
            errors++; $display("FAIL par_rd_data port %0d got %h exp %h", i, data_RT_out[i], exp_out[i]); end
      end
      re_RT = '0;
      @(negedge clk);
   endtask

   task automatic test_we_re();
      we_RT[2] = 1'b1; re_RT[2] = 1'b1; addr_RT[2] = 32'h9; data_RT_in[2] = 128'h77;
      step();
      checks++; if (rdy_RT[2] !== 1'b1) begin errors++; $display("FAIL wre_rdy got %b exp 1", rdy_RT[2]); end
      checks++; if (data_RT_out[2] !== exp_out[2]) begin
         errors++; $display("FAIL wre_data_hold got %h exp %h", data_RT_out[2], exp_out[2]); end
      we_RT[2] = 1'b0; re_RT[2] = 1'b0;
      @(negedge clk);
      re_RT[2] = 1'b1;
      step();
      checks++; if (data_RT_out[2] !== 128'h77) begin
         errors++; $display("FAIL wre_readback got %h exp 77", data_RT_out[2]); end
      exp_out[2] = 128'h77;
      re_RT[2] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_alias();
      logic [DATA_W-1:0] d;
      d = rand_word();
      c4_data = rand_word();
      we_RT[1] = 1'b1; addr_RT[1] = 32'(SPAN + 3); data_RT_in[1] = d;
      we_RT[3] = 1'b1; addr_RT[3] = 32'h4; data_RT_in[3] = c4_data;
      step();
      checks++; if (rdy_RT !== 4'b1010) begin errors++; $display("FAIL alias_wr_rdy got %b exp 1010", rdy_RT); end
      we_RT = '0;
      @(negedge clk);
      re_RT[3] = 1'b1; addr_RT[3] = 32'h3;
      step();
      checks++; if (data_RT_out[3] !== d) begin
         errors++; $display("FAIL alias_rd_data got %h exp %h", data_RT_out[3], d); end
      re_RT = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      re_RT[1] = 1'b1; addr_RT[1] = 32'h5;
      #2 rst_n = 1'b0;
      step();
      checks++; if (rdy_RT !== '0) begin errors++; $display("FAIL rstmid_rdy_rt got %b exp 0", rdy_RT); end
      checks++; if (rdy_MC !== 1'b0) begin errors++; $display("FAIL rstmid_rdy_mc got %b exp 0", rdy_MC); end
      checks++; if (data_RT_out !== '0) begin errors++; $display("FAIL rstmid_data_rt got %h exp 0", data_RT_out); end
      checks++; if (data_MC_out !== '0) begin errors++; $display("FAIL rstmid_data_mc got %h exp 0", data_MC_out); end
      re_RT = '0;
      rst_n = 1'b1;
      for (int i = 0; i < NUM_RT; i++) exp_out[i] = '0;
   endtask

   // Relies on the pointer reset left by test_reset_mid.
   task automatic test_conflict();
      int seq [10];
      logic [NUM_RT:0] e;
`ifdef MEM_MC_PRIORITY_EN
      seq = '{4, 0, 4, 1, 4, 2, 4, 3, 4, 0};
`else
      seq = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
`endif
      @(negedge clk);
      for (int i = 0; i < NUM_RT; i++) begin re_RT[i] = 1'b1; addr_RT[i] = 32'h4; end
      re_MC = 1'b1; addr_MC = 32'h4;
      for (int k = 0; k < 10; k++) begin
         step();
         e = '0; e[seq[k]] = 1'b1;
         checks++; if ({rdy_MC, rdy_RT} !== e) begin
            errors++; $display("FAIL conflict_grant cycle %0d got %b exp %b", k, {rdy_MC, rdy_RT}, e); end
         if (seq[k] == NUM_RT) begin
            checks++; if (data_MC_out !== c4_data) begin
               errors++; $display("FAIL conflict_mc_data got %h exp %h", data_MC_out, c4_data); end
         end else begin
            checks++; if (data_RT_out[seq[k]] !== c4_data) begin
               errors++; $display("FAIL conflict_rt_data port %0d got %h exp %h", seq[k], data_RT_out[seq[k]], c4_data); end
         end
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_random();
      int win, key;
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mdl.delete();
      for (int b = 0; b < NUM_BANK; b++) mptr[b] = 0;
      for (int c = 0; c < NUM_C; c++) begin
         act[c] = 1'b0; wop[c] = 1'b0; rop[c] = 1'b0; ta[c] = '0; td[c] = '0;
         cur_rdy[c] = 1'b0; ed[c] = '0; ck[c] = 1'b1;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < NUM_RT; i++) begin
            checks++; if (rdy_RT[i] !== cur_rdy[i]) begin
               errors++; $display("FAIL rand_rdy_rt cyc %0d port %0d got %b exp %b", cyc, i, rdy_RT[i], cur_rdy[i]); end
            if (ck[i]) begin
               checks++; if (data_RT_out[i] !== ed[i]) begin
                  errors++; $display("FAIL rand_data_rt cyc %0d port %0d got %h exp %h", cyc, i, data_RT_out[i], ed[i]); end
            end
         end
         checks++; if (rdy_MC !== cur_rdy[NUM_RT]) begin
            errors++; $display("FAIL rand_rdy_mc cyc %0d got %b exp %b", cyc, rdy_MC, cur_rdy[NUM_RT]); end
         if (ck[NUM_RT]) begin
            checks++; if (data_MC_out !== ed[NUM_RT]) begin
               errors++; $display("FAIL rand_data_mc cyc %0d got %h exp %h", cyc, data_MC_out, ed[NUM_RT]); end
         end
         // Requesters: finish on rdy, then possibly start a new access.
         for (int c = 0; c < NUM_C; c++) begin
            if (cur_rdy[c]) act[c] = 1'b0;
            if (!act[c] && $urandom_range(0, 2) != 0) begin
               act[c] = 1'b1;
               ta[c]  = 32'(64 + $urandom_range(0, 15)) + 32'($urandom_range(0, 3)) * 32'(SPAN);
               td[c]  = rand_word();
               if (c < NUM_RT) begin
                  case ($urandom_range(0, 3))
                     0: begin wop[c] = 1'b1; rop[c] = 1'b0; end
                     3: begin wop[c] = 1'b1; rop[c] = 1'b1; end
                     default: begin wop[c] = 1'b0; rop[c] = 1'b1; end
                  endcase
               end else begin
                  wop[c] = 1'b0; rop[c] = 1'b1;
               end
            end
         end
         for (int i = 0; i < NUM_RT; i++) begin
            we_RT[i] = act[i] && wop[i];
            re_RT[i] = act[i] && rop[i];
            addr_RT[i] = ta[i];
            data_RT_in[i] = td[i];
         end
         re_MC = act[NUM_RT];
         addr_MC = ta[NUM_RT];
         // Model: per bank, first requester at or after the pointer wins.
         for (int c = 0; c < NUM_C; c++) begin
            req[c] = act[c] && !cur_rdy[c];
            nxt_rdy[c] = 1'b0;
         end
         for (int b = 0; b < NUM_BANK; b++) begin
            win = -1;
`ifdef MEM_MC_PRIORITY_EN
            if (req[NUM_RT] && int'(ta[NUM_RT] % NUM_BANK) == b) win = NUM_RT;
            for (int k = 0; k < NUM_RT; k++) begin
               int c;
               c = (mptr[b] + k) % NUM_RT;
               if (win < 0 && req[c] && int'(ta[c] % NUM_BANK) == b) begin
                  win = c; mptr[b] = (c + 1) % NUM_RT;
               end
            end
`else
            for (int k = 0; k < NUM_C; k++) begin
               int c;
               c = (mptr[b] + k) % NUM_C;
               if (win < 0 && req[c] && int'(ta[c] % NUM_BANK) == b) begin
                  win = c; mptr[b] = (c + 1) % NUM_C;
               end
            end
`endif
            if (win >= 0) begin
               nxt_rdy[win] = 1'b1;
               key = int'(ta[win] % SPAN);
               if (wop[win]) mdl[key] = td[win];
               else if (mdl.exists(key)) begin ed[win] = mdl[key]; ck[win] = 1'b1; end
               else ck[win] = 1'b0;
            end
         end
         for (int c = 0; c < NUM_C; c++) cur_rdy[c] = nxt_rdy[c];
         step();
      end
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      c4_data = '0;
      @(negedge clk);
      test_reset();
      test_uncontended();
      test_parallel();
      test_we_re();
      test_alias();
      test_reset_mid();
      test_conflict();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
